// File: rtl/multibank_access_arbiter_if.sv
// Requester/bank bus bundle for the 4-bank access arbiter.
// slave = arbiter side; master = requesters plus bank instances.
interface multibank_access_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  localparam int BW = ADDR_WIDTH - 2;

  logic                       i_a_req, i_a_we;
  logic [ADDR_WIDTH-1:0]      i_a_addr;
  logic [DATA_WIDTH-1:0]      i_a_wdata;
  logic                       o_a_gnt, o_a_rvalid;
  logic [DATA_WIDTH-1:0]      o_a_rdata;

  logic                       i_b_req, i_b_we;
  logic [ADDR_WIDTH-1:0]      i_b_addr;
  logic [DATA_WIDTH-1:0]      i_b_wdata;
  logic                       o_b_gnt, o_b_rvalid;
  logic [DATA_WIDTH-1:0]      o_b_rdata;

  logic [3:0]                 o_bank_en, o_bank_we;
  logic [3:0][BW-1:0]         o_bank_addr;
  logic [3:0][DATA_WIDTH-1:0] o_bank_wdata;
  logic [3:0][DATA_WIDTH-1:0] i_bank_rdata;
  logic [CNT_WIDTH-1:0]       o_conflict_cnt;

  modport slave (
    input  i_a_req, i_a_we, i_a_addr, i_a_wdata,
    input  i_b_req, i_b_we, i_b_addr, i_b_wdata,
    input  i_bank_rdata,
    output o_a_gnt, o_a_rvalid, o_a_rdata,
    output o_b_gnt, o_b_rvalid, o_b_rdata,
    output o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata, o_conflict_cnt
  );

  modport master (
    output i_a_req, i_a_we, i_a_addr, i_a_wdata,
    output i_b_req, i_b_we, i_b_addr, i_b_wdata,
    output i_bank_rdata,
    input  o_a_gnt, o_a_rvalid, o_a_rdata,
    input  o_b_gnt, o_b_rvalid, o_b_rdata,
    input  o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata, o_conflict_cnt
  );
endinterface

// File: rtl/multibank_access_arbiter.sv
// Two-requester, four-bank arbiter: parallel grants across banks,
// round-robin on same-bank conflicts, 1-cycle read return.
module multibank_bank_lane #(
  parameter int BW  = 4,
  parameter int DW  = 8,
  parameter int IDX = 0
) (
  input  logic          a_gnt,
  input  logic          a_we,
  input  logic [1:0]    a_bank,
  input  logic [BW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_gnt,
  input  logic          b_we,
  input  logic [1:0]    b_bank,
  input  logic [BW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          en,
  output logic          we,
  output logic [BW-1:0] addr,
  output logic [DW-1:0] wdata
);
  logic a_hit, b_hit;
  assign a_hit = a_gnt && (a_bank == 2'(IDX));
  assign b_hit = b_gnt && (b_bank == 2'(IDX));

  // both hitting the same bank is impossible: that case is a conflict
  always_comb begin
    en    = a_hit | b_hit;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (a_hit) begin
      we = a_we; addr = a_addr; wdata = a_wdata;
    end else if (b_hit) begin
      we = b_we; addr = b_addr; wdata = b_wdata;
    end
  end
endmodule

module multibank_access_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  multibank_access_arbiter_if.slave bus
);
  localparam int BW        = ADDR_WIDTH - 2;
  localparam int NUM_BANKS = 4;

  logic [1:0]                         a_bank, b_bank;
  logic                               conflict, prio_b, a_gnt, b_gnt;
  logic [NUM_BANKS-1:0]               bank_en, bank_we;
  logic [NUM_BANKS-1:0][BW-1:0]       bank_addr;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata, bank_rdata;
  logic                               a_rv_q, b_rv_q;
  logic [1:0]                         a_rbank_q, b_rbank_q;
  logic [DATA_WIDTH-1:0]              a_hold, b_hold;
  logic [CNT_WIDTH-1:0]               cnt_q;

  assign a_bank   = bus.i_a_addr[ADDR_WIDTH-1 -: 2];
  assign b_bank   = bus.i_b_addr[ADDR_WIDTH-1 -: 2];
  assign conflict = bus.i_a_req && bus.i_b_req && (a_bank == b_bank);
  assign a_gnt    = !i_rst && bus.i_a_req && (!conflict || !prio_b);
  assign b_gnt    = !i_rst && bus.i_b_req && (!conflict ||  prio_b);

  assign bus.o_a_gnt = a_gnt;
  assign bus.o_b_gnt = b_gnt;

  for (genvar n = 0; n < NUM_BANKS; n++) begin : g_lane
    multibank_bank_lane #(.BW(BW), .DW(DATA_WIDTH), .IDX(n)) u_lane (
      .a_gnt  (a_gnt),        .a_we   (bus.i_a_we),
      .a_bank (a_bank),       .a_addr (bus.i_a_addr[BW-1:0]),
      .a_wdata(bus.i_a_wdata),
      .b_gnt  (b_gnt),        .b_we   (bus.i_b_we),
      .b_bank (b_bank),       .b_addr (bus.i_b_addr[BW-1:0]),
      .b_wdata(bus.i_b_wdata),
      .en     (bank_en[n]),   .we     (bank_we[n]),
      .addr   (bank_addr[n]), .wdata  (bank_wdata[n])
    );
  end

  assign bus.o_bank_en    = bank_en;
  assign bus.o_bank_we    = bank_we;
  assign bus.o_bank_addr  = bank_addr;
  assign bus.o_bank_wdata = bank_wdata;
  assign bank_rdata       = bus.i_bank_rdata;

  // a pending pulse is dropped as soon as reset is seen
  assign bus.o_a_rvalid = a_rv_q && !i_rst;
  assign bus.o_b_rvalid = b_rv_q && !i_rst;
  assign bus.o_a_rdata  = bus.o_a_rvalid ? bank_rdata[a_rbank_q] : a_hold;
  assign bus.o_b_rdata  = bus.o_b_rvalid ? bank_rdata[b_rbank_q] : b_hold;
  assign bus.o_conflict_cnt = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_b    <= 1'b0;
      cnt_q     <= '0;
      a_rv_q    <= 1'b0;
      b_rv_q    <= 1'b0;
      a_rbank_q <= '0;
      b_rbank_q <= '0;
      a_hold    <= '0;
      b_hold    <= '0;
    end else begin
      if (conflict) begin
        prio_b <= !prio_b;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      a_rv_q <= a_gnt && !bus.i_a_we;
      b_rv_q <= b_gnt && !bus.i_b_we;
      if (a_gnt && !bus.i_a_we) a_rbank_q <= a_bank;
      if (b_gnt && !bus.i_b_we) b_rbank_q <= b_bank;
      a_hold <= bus.o_a_rdata;
      b_hold <= bus.o_b_rdata;
    end
  end
endmodule
